dm_access_ctrl: RTL
===================

// Module: dm_access_ctrl
// PURPOSE
//  Load/store sequencer between the CPU memory stage and the word-wide data memory (dm).
//  Turns CPU byte/half/word load and store requests into dm word accesses: read-modify-write
//  for sub-word stores, lane extraction plus sign/zero extension for sub-word loads.
//  Checks alignment and range, and reports completion through a req/busy/done handshake.
// PARAMETERS
//  ADDR_W      12    dm byte-address width (dm_addr width)
//  DEPTH_BYTES 1024  valid dm bytes; accesses with any byte >= DEPTH_BYTES are out of range
// PORTS
//  clk      in   1   system clock, all state on posedge
//  rst      in   1   synchronous, active-high reset
//  req      in   1   access request, sampled only in IDLE
//  wr       in   1   1=store, 0=load (sampled with req)
//  size     in   2   00=byte, 01=half, 10=word, 11=illegal (err)
//  sext     in   1   loads only: 1=sign-extend, 0=zero-extend sub-word data
//  addr     in   32  CPU byte address
//  wdata    in   32  store data; byte/half taken from low bits
//  busy     out  1   high in every state except IDLE
//  done     out  1   one-cycle completion pulse
//  err      out  1   valid with done: misaligned, out of range, or illegal size; no dm write
//  rdata    out  32  load result; held until the next successful load completes
//  dm_addr  out  ADDR_W  word-aligned address to dm: {addr[ADDR_W-1:2],2'b00}
//  dm_din   out  32  word written to dm
//  dm_we    out  1   dm write enable
//  dm_dout  in   32  dm combinational read data, little-endian (byte 0 = bits 7:0)
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset rst is synchronous and active-high.
//  Reset: state=IDLE, busy=0, done=0, err=0, rdata=0, dm_we=0, dm_din=0.
//  dm_we = (state==WR) & ~rst. Asserting rst in WR therefore commits no write.
//  All request fields are latched at acceptance (IDLE & req). Later changes are ignored.
//  States and transitions:
//   IDLE: req & fault           -> DONE, err=1.
//         req & load            -> RD.
//         req & word store      -> WR.
//         req & sub-word store  -> RD.
//   RD:   capture dm_dout. Load -> DONE (update rdata). Sub-word store -> WR.
//   WR:   dm_we=1. dm_din = captured word with the addressed lane(s) replaced by wdata
//         (word store: dm_din=wdata). -> DONE.
//   DONE: done=1, err as latched. -> IDLE. req is ignored here; back-to-back issue is
//         one request per (latency+1) cycles.
//  Latency (accepting edge to the edge where done is first seen high):
//   load=2, word store=2, sub-word store=3, fault=1.
//  Lanes:
//   byte: lane=addr[1:0], bits [8*lane+7 : 8*lane].
//   half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//  Load extension: sext=1 replicates the top bit of the lane; sext=0 zero-fills.
//   Word loads ignore sext.
//  Faults (no RD/WR, dm untouched, rdata unchanged):
//   half with addr[0]=1; word with addr[1:0]!=0; size=11; addr >= DEPTH_BYTES.
//   Any nonzero addr[31:ADDR_W] is out of range.
//  Unlatched dm_addr only matters in RD/WR. dm_addr is driven from the latched address.
//  rst in any state returns to IDLE on the next edge. A pending done is dropped.
// CONFIGURATION
//  DM_ACCESS_SUBWORD_EN defined:
//   byte/half loads and stores supported as above (RMW path present).
//  Not defined:
//   only size=10 is legal. size 00/01 faults (done+err after 1 cycle).
//   The RD->WR path and the lane logic are removed.
// TESTING
//  1. sw addr=0x010, wdata=0xDEADBEEF -> dm_we one cycle, dm_din=0xDEADBEEF; done 2 cycles after accept, err=0.
//  2. After 1: lb addr=0x013 sext=1 -> rdata=0xFFFFFFDE; lbu addr=0x011 -> rdata=0x000000BE.
//  3. After 1: sb addr=0x012, wdata=0x55 -> RD,WR sequence; dm word 0x010 = 0xDE55BEEF; done at 3 cycles.
//  4. lh addr=0x011 -> done+err at 1 cycle, dm_we never high, rdata unchanged; same for addr=0x400 word load.
//  5. sh addr=0x012, wdata=0x1234 with rst asserted in WR cycle -> no dm write, busy=0 next cycle, word still 0xDEADBEEF.
//  6. Without DM_ACCESS_SUBWORD_EN: lb addr=0x010 -> err=1 after 1 cycle; lw addr=0x010 -> 0xDEADBEEF.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// CPU-side load/store handshake between the memory stage and dm_access_ctrl.
// The master modport is the CPU and the slave modport is the sequencer.
interface dm_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, sext, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, wr, size, sext, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the CPU memory stage and the word-wide data memory.
// Sub-word loads/stores (read-modify-write path) exist only with DM_ACCESS_SUBWORD_EN defined.
module dm_access_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_ctrl_if.slave   cpu,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              accept_fault;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       store_word;
`ifdef DM_ACCESS_SUBWORD_EN
    logic [1:0]        size_q;
    logic              sext_q;
    logic [31:0]       word_q;
`else
    logic              unused_subword;
`endif

    // Any byte of the access beyond the last valid dm byte, a misaligned half/word,
    // or a size this build cannot serve turns the request into an error completion.
    function automatic logic req_fault(input logic [1:0] size, input logic [31:0] addr);
        logic        bad_size;
        logic        misalign;
        logic [1:0]  nb_m1;
        logic [32:0] last_byte;
`ifdef DM_ACCESS_SUBWORD_EN
        bad_size = (size == 2'b11);
`else
        bad_size = (size != 2'b10);
`endif
        misalign  = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
        nb_m1     = (size == 2'b10) ? 2'd3 : ((size == 2'b01) ? 2'd1 : 2'd0);
        last_byte = {1'b0, addr} + {31'd0, nb_m1};
        return bad_size | misalign | (|addr[31:ADDR_W]) | (last_byte >= 33'(DEPTH_BYTES));
    endfunction

`ifdef DM_ACCESS_SUBWORD_EN
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = sext ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   r = sext ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[8*lane +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction
`endif

    assign accept       = (state == IDLE) && cpu.req;
    assign accept_fault = req_fault(cpu.size, cpu.addr);

`ifdef DM_ACCESS_SUBWORD_EN
    assign store_word = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
`else
    assign store_word = wdata_q;
    assign unused_subword = ^{cpu.sext, addr_q[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu.busy  = 1'b0;
        cpu.done  = 1'b0;
        cpu.err   = 1'b0;
        dm_we     = 1'b0;
        dm_din    = 32'd0;
        case (state)
            IDLE: begin
                if (cpu.req) begin
                    if (accept_fault)                   state_nxt = DONE;
                    else if (cpu.wr && cpu.size == 2'b10) state_nxt = WR;
                    else                                state_nxt = RD;
                end
            end
            RD: begin
                cpu.busy = 1'b1;
`ifdef DM_ACCESS_SUBWORD_EN
                state_nxt = wr_q ? WR : DONE;
`else
                state_nxt = DONE;
`endif
            end
            WR: begin
                cpu.busy  = 1'b1;
                dm_we     = ~rst;
                dm_din    = store_word;
                state_nxt = DONE;
            end
            DONE: begin
                cpu.busy  = 1'b1;
                cpu.done  = 1'b1;
                cpu.err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= cpu.wr;
            addr_q  <= cpu.addr[ADDR_W-1:0];
            wdata_q <= cpu.wdata;
`ifdef DM_ACCESS_SUBWORD_EN
            size_q  <= cpu.size;
            sext_q  <= cpu.sext;
`endif
        end
`ifdef DM_ACCESS_SUBWORD_EN
        if (state == RD) begin
            word_q <= dm_dout;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                err_q <= accept_fault;
            end
            if (state == RD && !wr_q) begin
`ifdef DM_ACCESS_SUBWORD_EN
                rdata_q <= load_extend(dm_dout, size_q, addr_q[1:0], sext_q);
`else
                rdata_q <= dm_dout;
`endif
            end
        end
    end

    assign cpu.rdata = rdata_q;
    assign dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};

endmodule
